// File: rtl/digest_splice_pkg.sv
// Shared types and helpers for the digest splice datapath.
// Holds the splice FSM state encoding, the MODE selector values and the
// helper that builds the byte-enable mask covering a digest beat.
package digest_splice_pkg;

  // Splice FSM: forwarding packet data, or waiting for the packet's digest
  typedef enum logic {
    S_PASS = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  // MODE values: overwrite the final data beat, or add the digest after it
  localparam int MODE_REPLACE = 0;
  localparam int MODE_APPEND  = 1;

  // Widest keep vector the mask helper can describe (2048-bit data bus)
  localparam int MAX_KEEP_W = 256;

  // Byte-enable mask with one bit set per digest byte, starting at byte 0
  function automatic logic [MAX_KEEP_W-1:0] digest_keep_mask(input int digest_width);
    logic [MAX_KEEP_W-1:0] mask;
    mask = '0;
    for (int i = 0; i < MAX_KEEP_W; i++) begin
      if (i < digest_width / 8) mask[i] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/digest_splice_mux_out_reg.sv
// splice_out_reg: single-entry AXI-Stream style output register.
// Accepts a new payload whenever the slot is empty or being drained in the
// same cycle, and holds its contents stable while the consumer stalls.
// The caller must only raise load while slot_free is high.
module splice_out_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] next_payload,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] payload,
  output logic             slot_free
);

  // The slot can take a new beat when empty or when its beat leaves this cycle
  assign slot_free = !valid || ready;

  // Valid flag: set by a load, cleared once the consumer takes the beat
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

  // Payload storage, cleared on reset so an idle bus reads as zero
  always_ff @(posedge clk) begin
    if (rst) begin
      payload <= '0;
    end else if (load) begin
      payload <= next_payload;
    end
  end

endmodule

// File: rtl/digest_splice_mux.sv
// digest_splice_mux: merges a packet data stream with a one-beat-per-packet
// digest stream. MODE=0 replaces the packet's last data beat with the
// digest; MODE=1 appends the digest as an extra beat after the packet.
// Build macro SPLICE_STATS_EN enables the packet/error counters and the
// digest tid check; without it those outputs are tied to zero.
module digest_splice_mux
  import digest_splice_pkg::*;
#(
  parameter int DATA_WIDTH   = 512,
  parameter int DIGEST_WIDTH = 256,
  parameter int ID_WIDTH     = 6,
  parameter int MODE         = 0
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [DATA_WIDTH-1:0]   inp_data,
  input  logic                    inp_valid,
  output logic                    inp_ready,
  input  logic [DATA_WIDTH/8-1:0] inp_keep,
  input  logic [ID_WIDTH-1:0]     inp_id,
  input  logic                    inp_last,
  input  logic [DIGEST_WIDTH-1:0] chk_data,
  input  logic                    chk_valid,
  output logic                    chk_ready,
  input  logic [ID_WIDTH-1:0]     chk_id,
  output logic [DATA_WIDTH-1:0]   out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH/8-1:0] out_keep,
  output logic [ID_WIDTH-1:0]     out_id,
  output logic                    out_last,
  output logic                    id_mismatch,
  output logic [31:0]             pkt_count,
  output logic [15:0]             err_count
);

  localparam int KEEP_W    = DATA_WIDTH / 8;
  localparam int PAYLOAD_W = DATA_WIDTH + KEEP_W + ID_WIDTH + 1;

  // Byte enables for a digest beat: the low DIGEST_WIDTH/8 lanes only
  localparam logic [MAX_KEEP_W-1:0] DIGEST_KEEP_FULL = digest_keep_mask(DIGEST_WIDTH);
  localparam logic [KEEP_W-1:0]     DIGEST_KEEP      = DIGEST_KEEP_FULL[KEEP_W-1:0];

  state_t                  state;
  logic [ID_WIDTH-1:0]     pkt_id;
  logic                    slot_free;
  logic                    inp_hs;
  logic                    chk_hs;
  logic                    data_load;
  logic                    load;
  logic [DATA_WIDTH-1:0]   digest_ext;
  logic [PAYLOAD_W-1:0]    next_payload;
  logic [PAYLOAD_W-1:0]    payload;

  // Only one of the two inputs is ever open, chosen by the FSM state, and
  // both stay closed while reset is asserted.
  assign inp_ready = !areset && (state == S_PASS) && slot_free;
  assign chk_ready = !areset && (state == S_WAIT) && slot_free;

  assign inp_hs = inp_valid && inp_ready;
  assign chk_hs = chk_valid && chk_ready;

  // Non-last beats always go out; the last beat only goes out when the
  // digest is appended rather than substituted.
  assign data_load = inp_hs && (!inp_last || (MODE == MODE_APPEND));
  assign load      = data_load || chk_hs;

  // Place the digest in the low lanes of the data bus, zero above
  always_comb begin
    digest_ext = '0;
    digest_ext[DIGEST_WIDTH-1:0] = chk_data;
  end

  // Choose the beat presented to the output register. Data beats always
  // leave with last clear: in append mode the packet's final beat is no
  // longer the end of the output packet.
  always_comb begin
    next_payload = {inp_data, inp_keep, inp_id, 1'b0};
    if (state == S_WAIT) begin
      next_payload = {digest_ext, DIGEST_KEEP, pkt_id, 1'b1};
    end
  end

  splice_out_reg #(
    .WIDTH(PAYLOAD_W)
  ) u_out_reg (
    .clk         (aclk),
    .rst         (areset),
    .load        (load),
    .next_payload(next_payload),
    .ready       (out_ready),
    .valid       (out_valid),
    .payload     (payload),
    .slot_free   (slot_free)
  );

  assign {out, out_keep, out_id, out_last} = payload;

  // Splice FSM: forward data until the last beat, then wait for one digest
  always_ff @(posedge aclk) begin
    if (areset) begin
      state <= S_PASS;
    end else begin
      case (state)
        S_PASS:  if (inp_hs && inp_last) state <= S_WAIT;
        S_WAIT:  if (chk_hs) state <= S_PASS;
        default: state <= S_PASS;
      endcase
    end
  end

  // Remember the tid of the packet in flight so the digest beat carries it
  always_ff @(posedge aclk) begin
    if (inp_hs) pkt_id <= inp_id;
  end

`ifdef SPLICE_STATS_EN
  logic id_bad;

  assign id_bad = (chk_id != pkt_id);

  // Packet counter (wrapping), tid error counter (saturating) and sticky flag
  always_ff @(posedge aclk) begin
    if (areset) begin
      pkt_count   <= '0;
      err_count   <= '0;
      id_mismatch <= 1'b0;
    end else if (chk_hs) begin
      pkt_count <= pkt_count + 32'd1;
      if (id_bad) begin
        id_mismatch <= 1'b1;
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
      end
    end
  end
`else
  logic unused_chk_id;

  // Without statistics the digest tid is not examined at all
  assign unused_chk_id = ^chk_id;
  assign pkt_count     = '0;
  assign err_count     = '0;
  assign id_mismatch   = 1'b0;
`endif

endmodule

// File: doc/digest_splice_mux.md
Name: digest_splice_mux

Overview:
Parametrised successor to the single-mode last-beat checksum replacer. Sits after the stream duplicator and the digest FIFO. Merges a data stream with a one-beat-per-packet digest stream (SHA-256 or similar), either replacing the final data beat with the digest or appending the digest as an extra beat. Also checks that the digest tid matches the packet tid and keeps statistics.

Parameters:
DATA_WIDTH, 512, data bus width in bits; must be a multiple of 8.
DIGEST_WIDTH, 256, digest width in bits; must be a multiple of 8 and at most DATA_WIDTH.
ID_WIDTH, 6, tid width.
MODE, 0, 0 = replace the last data beat; 1 = append the digest after the last data beat.

Ports:
aclk  in  1  clock
areset  in  1  synchronous reset, active-high
inp_data  in  DATA_WIDTH  data tdata
inp_valid  in  1  data tvalid
inp_ready  out  1  data tready
inp_keep  in  DATA_WIDTH/8  data tkeep
inp_id  in  ID_WIDTH  data tid
inp_last  in  1  data tlast
chk_data  in  DIGEST_WIDTH  digest tdata
chk_valid  in  1  digest tvalid
chk_ready  out  1  digest tready
chk_id  in  ID_WIDTH  digest tid
out  out  DATA_WIDTH  output tdata
out_valid  out  1  output tvalid
out_ready  in  1  output tready
out_keep  out  DATA_WIDTH/8  output tkeep
out_id  out  ID_WIDTH  output tid
out_last  out  1  output tlast
id_mismatch  out  1  sticky: a digest tid did not match its packet tid
pkt_count  out  32  packets completed
err_count  out  16  tid mismatches, saturating

Behaviour:
- Clock and reset: one clock, aclk. Reset areset is synchronous and active-high.
- Reset values:
  - state = S_PASS.
  - out_valid = 0; out, out_keep, out_id and out_last = 0.
  - inp_ready = 0 and chk_ready = 0 during reset.
  - id_mismatch = 0; pkt_count = 0; err_count = 0.
- Reset mid-packet: the partial packet state is dropped and the next beat is treated as a packet start.
- Output stage: a single register. slot_free = !out_valid || out_ready. out_* are stable while out_valid && !out_ready.
- S_PASS:
  - inp_ready = slot_free; chk_ready = 0.
  - On an inp handshake, capture inp_id into pkt_id.
  - Non-last beat: loaded into the output register unchanged. Latency is 1 cycle.
  - Last beat with MODE=0: consumed but not emitted; go to S_WAIT.
  - Last beat with MODE=1: emitted with out_last forced to 0; go to S_WAIT.
- S_WAIT:
  - inp_ready = 0; chk_ready = slot_free.
  - On a chk handshake, load the output register:
    - out = digest in the low DIGEST_WIDTH bits, zero above;
    - out_keep = low DIGEST_WIDTH/8 bits set, rest clear;
    - out_id = pkt_id; out_last = 1.
  - Increment pkt_count, which wraps. Return to S_PASS.
  - Digest-to-output latency is 1 cycle.
- Digest arriving early (while in S_PASS): held off by chk_ready=0 and never dropped.
- Single-beat packet:
  - MODE=0: only the digest beat is emitted.
  - MODE=1: the data beat (last=0) is emitted, then the digest beat.
- tid check: on a chk handshake with chk_id != pkt_id, set id_mismatch, which stays set until reset. err_count increments and saturates at 16'hFFFF. The digest is still emitted, with out_id = pkt_id.
- Back-to-back packets: after the digest beat is loaded, S_PASS accepts the next data beat on the following cycle. Sustained throughput is 1 beat per cycle within a packet, plus 1 digest cycle per packet.
- inp_keep is not inspected; it is passed through on non-last data beats.

Optional Feature:
SPLICE_STATS_EN.
- Defined: pkt_count, err_count and id_mismatch are implemented as above.
- Undefined: these counters and the flag are not synthesised and the three outputs are tied to 0. The tid comparison logic is removed. Datapath behaviour is identical.

Decomposition:
- Shared package digest_splice_pkg:
  - state enum (S_PASS, S_WAIT);
  - MODE_REPLACE = 0 and MODE_APPEND = 1;
  - a function building the digest tkeep mask from DIGEST_WIDTH.
- One sub-module, splice_out_reg: the single-entry output register with slot_free logic, reusable by other stream blocks. The FSM and statistics stay in the top.

Test Plan:
- MODE=0, 4-beat packet with tid=3 and all-ones keep, digest 256'hA5...A5 with tid=3 → 4 output beats. Beats 0–2 are unchanged; beat 3 carries out[255:0]=A5..A5, out[511:256]=0, out_keep=64'h0000_0000_FFFF_FFFF, out_last=1, out_id=3. pkt_count=1.
- MODE=1, same stimulus → 5 output beats. Beat 3 is the original data with last=0; beat 4 is the digest with last=1.
- Digest presented 10 cycles before the packet's first beat → chk_ready stays 0 until the last data beat is accepted. The digest is emitted exactly once.
- out_ready toggled 1/0 every cycle during a 3-packet burst → no beat is lost or duplicated, and out_* are stable while stalled.
- Digest tid=5 for a packet with tid=2 → digest beat emitted with out_id=2; id_mismatch=1 and err_count=1. After reset, both are 0.
- areset asserted after beat 2 of a 4-beat packet, then a fresh 1-beat packet with MODE=0 → output is a single digest beat with last=1, and out_valid was 0 on the cycle after reset.
